// File: rtl/mux_4to1_rr_stream_pkg.sv
// Constants shared by the 4-to-1 round-robin stream mux and the matching demux benches.
package mux_4to1_rr_stream_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    // Pointer advance after a grant; the 2-bit width gives the 3 -> 0 wrap.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
        return g + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter: first request found at or after ptr wins.
module rr_arbiter_4
    import mux_4to1_rr_stream_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_4to1_rr_stream.sv
// Four valid/ready source channels merged onto one registered stream with a sel tag.
module mux_4to1_rr_stream
    import mux_4to1_rr_stream_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic [N_CH-1:0]   i_valid,
    output logic [N_CH-1:0]   i_ready,
    output logic [DATA_W-1:0] o,
    output logic [SEL_W-1:0]  sel,
    output logic              o_valid,
    input  logic              o_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [N_CH-1:0]   gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any;
    logic              load_en;
    logic              load;
    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] o_p1;
    logic [SEL_W-1:0]  sel_p1;
    logic              vld_p1;

    rr_arbiter_4 u_arb (
        .req        (i_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Stage p0: arbitration and source select
    assign load_en = ~vld_p1 | o_ready;
    assign load    = load_en & any & ~rst;
    assign i_ready = load ? gnt_onehot : '0;

    always_comb begin
        data_p0 = '0;
        case (gnt_idx)
            2'd0:    data_p0 = i0;
            2'd1:    data_p0 = i1;
            2'd2:    data_p0 = i2;
            default: data_p0 = i3;
        endcase
    end

    // Stage p1: output register; reset also clears the held word
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            o_p1   <= '0;
            sel_p1 <= '0;
            ptr    <= '0;
        end else if (load) begin
            vld_p1 <= 1'b1;
            o_p1   <= data_p0;
            sel_p1 <= gnt_idx;
            ptr    <= next_ptr(gnt_idx);
        end else if (o_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign o       = o_p1;
    assign sel     = sel_p1;
    assign o_valid = vld_p1;

endmodule

// File: tb/tb_mux_4to1_rr_stream.sv
// Scoreboard bench for mux_4to1_rr_stream: directed cases plus randomized traffic.
module tb_mux_4to1_rr_stream;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] s;
    } word_t;

    logic       clk;
    logic       rst;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] i_valid;
    logic [3:0] i_ready;
    logic [3:0] o;
    logic [1:0] sel;
    logic       o_valid;
    logic       o_ready;

    mux_4to1_rr_stream #(.DATA_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o       (o),
        .sel     (sel),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: which channel is searched first and whether a word is on the output.
    int    m_ptr;
    bit    m_full;
    word_t q[$];
    int    n_chk, n_pass;
    int    mon_chk, mon_pass;
    logic [3:0] dmx [4];

    task automatic chk_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: apply inputs, predict the grant, advance the model, step past the edge.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                         input logic rdy);
        logic [3:0] exp_rdy;
        logic [3:0] dat [4];
        int g;
        rst = r; i_valid = v; i0 = a; i1 = b; i2 = c; i3 = d; o_ready = rdy;
        dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!r && (!m_full || rdy)) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk_eq("i_ready", int'(i_ready), int'(exp_rdy));
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (g >= 0) begin
            q.push_back('{d: dat[g], s: 2'(g)});
            m_full = 1'b1;
            m_ptr  = (g + 1) % 4;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_eq("o_valid", int'(o_valid), int'(m_full));
        if (r) begin
            q.delete();
            chk_eq("reset_o", int'(o), 0);
            chk_eq("reset_sel", int'(sel), 0);
        end
    endtask

    // Monitor: the head of the queue must be the word currently on the output.
    always @(negedge clk) begin
        if (o_valid) begin
            mon_chk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_word: got o=%0d sel=%0d with nothing expected", o, sel);
            end else if (o !== q[0].d || sel !== q[0].s) begin
                $display("FAIL out_word: got o=%0d sel=%0d expected o=%0d sel=%0d (t=%0t)",
                         o, sel, q[0].d, q[0].s, $time);
            end else begin
                mon_pass++;
            end
            if (o_ready && q.size() != 0) begin
                dmx[sel] = o;
                void'(q.pop_front());
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; mon_chk = 0; mon_pass = 0;
        m_ptr = 0; m_full = 1'b0;
        for (int k = 0; k < 4; k++) dmx[k] = 4'h0;
        rst = 1'b1; i_valid = '0; i0 = '0; i1 = '0; i2 = '0; i3 = '0; o_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        // Round-robin order and demux routing
        repeat (5) cycle(1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
        chk_eq("demux_o0", int'(dmx[0]), 10);
        chk_eq("demux_o1", int'(dmx[1]), 11);
        chk_eq("demux_o2", int'(dmx[2]), 12);
        chk_eq("demux_o3", int'(dmx[3]), 13);

        // Backpressure
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
        repeat (3) cycle(1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0);
        chk_eq("held_o", int'(o), 10);
        chk_eq("held_sel", int'(sel), 0);
        repeat (3) cycle(1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);

        // Sparse request then wrap-around search
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 4'b0100, 4'h1, 4'h2, 4'hC, 4'h4, 1'b1);
        chk_eq("sparse_sel", int'(sel), 2);
        cycle(1'b0, 4'b0101, 4'h7, 4'h2, 4'hC, 4'h4, 1'b1);
        chk_eq("wrap_sel", int'(sel), 0);

        // Idle gap keeps the pointer
        repeat (5) cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cycle(1'b0, 4'hF, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
        chk_eq("post_idle_sel", int'(sel), 1);

        // Reset while a word is held
        cycle(1'b0, 4'hF, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
        cycle(1'b1, 4'hF, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
        cycle(1'b0, 4'hF, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
        chk_eq("post_reset_sel", int'(sel), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic r;
            logic rdy;
            r   = ($urandom_range(0, 49) == 0);
            rdy = r ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(r, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rdy);
        end

        // Drain
        for (int n = 0; n < 10 && q.size() != 0; n++)
            cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk_eq("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass + mon_pass, n_chk + mon_chk);
        $finish;
    end

endmodule
